// File: rtl/cube_stream_tx_if.sv
// -----------------------------------------------------------------------------
// cube_stream_tx_if
// Bundles the transmitter's request, RAM-read and byte-stream signals.
//   start_addr_in / start_data_in : one-cycle transfer requests
//   rd_en_out, rd_layer_out, rd_word_out, rd_data_in : local RAM read port
//   byte_vld_out, byte_rdy_in, byte_data_out, dc_out : byte handshake
//   busy_out, done_out : transfer status
// master = the transmitter, slave = the environment (RAM, SPI master, host).
// -----------------------------------------------------------------------------
interface cube_stream_tx_if;
  logic        start_addr_in;
  logic        start_data_in;
  logic        rd_en_out;
  logic [2:0]  rd_layer_out;
  logic [5:0]  rd_word_out;
  logic [23:0] rd_data_in;
  logic        byte_vld_out;
  logic        byte_rdy_in;
  logic [7:0]  byte_data_out;
  logic        dc_out;
  logic        busy_out;
  logic        done_out;

  modport master (
    input  start_addr_in, start_data_in, rd_data_in, byte_rdy_in,
    output rd_en_out, rd_layer_out, rd_word_out,
    output byte_vld_out, byte_data_out, dc_out, busy_out, done_out
  );

  modport slave (
    output start_addr_in, start_data_in, rd_data_in, byte_rdy_in,
    input  rd_en_out, rd_layer_out, rd_word_out,
    input  byte_vld_out, byte_data_out, dc_out, busy_out, done_out
  );
endinterface

// File: rtl/cube_stream_tx.sv
// -----------------------------------------------------------------------------
// cube_stream_tx
// Serialises either the 64-entry address table or a full 8-layer x 64-word
// frame from a local RAM into a command byte (dc=0) followed by data bytes
// (dc=1), offered on a valid/ready byte handshake.
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : synchronous active-high reset
//   bus     : cube_stream_tx_if.master (requests, RAM read, byte stream,
//             busy/done status)
// All outputs are registered; they are decoded from the next-state values so
// that they line up with the state they describe.
// -----------------------------------------------------------------------------
module cube_stream_tx (
  input  logic             clk_in,
  input  logic             rst_in,
  cube_stream_tx_if.master bus
);

  localparam logic [7:0] CUBE0414_ADDR_WR = 8'hcc;
  localparam logic [7:0] CUBE0414_DATA_WR = 8'hda;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4
  } state_t;

  // Picks the byte of the fetched word to present for the given byte index.
  function automatic logic [7:0] f_sel_byte(input logic [23:0] i_word,
                                            input logic [1:0]  i_idx,
                                            input logic        i_addr);
    logic [7:0] w_sel;
    if (i_addr) begin
      w_sel = i_word[7:0];
    end else begin
      case (i_idx)
        2'd0:    w_sel = i_word[23:16];
        2'd1:    w_sel = i_word[15:8];
        default: w_sel = i_word[7:0];
      endcase
    end
    return w_sel;
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_mode_addr, w_mode_addr_nxt;
  logic [2:0]  r_layer, w_layer_nxt;
  logic [5:0]  r_word, w_word_nxt;
  logic [1:0]  r_byte, w_byte_nxt;
  logic [23:0] r_word_data, w_word_data_nxt;
  logic        w_done_nxt;

  logic        w_accept;
  logic        w_last_byte;
  logic        w_last_word;

  logic        r_byte_vld, w_byte_vld;
  logic        r_dc, w_dc;
  logic [7:0]  r_byte_data, w_byte_data;
  logic        r_rd_en, w_rd_en;
  logic [2:0]  r_rd_layer, w_rd_layer;
  logic [5:0]  r_rd_word, w_rd_word;
  logic        r_busy, w_busy;
  logic        r_done, w_done;

  // The registered valid is what the downstream sees, so it defines acceptance.
  assign w_accept    = r_byte_vld & bus.byte_rdy_in;
  assign w_last_byte = r_mode_addr ? 1'b1 : (r_byte == 2'd2);
  assign w_last_word = (r_word == 6'd63) & (r_mode_addr | (r_layer == 3'd7));

  // State and counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_mode_addr <= 1'b0;
      r_layer     <= 3'd0;
      r_word      <= 6'd0;
      r_byte      <= 2'd0;
      r_word_data <= 24'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_addr <= w_mode_addr_nxt;
      r_layer     <= w_layer_nxt;
      r_word      <= w_word_nxt;
      r_byte      <= w_byte_nxt;
      r_word_data <= w_word_data_nxt;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_mode_addr_nxt = r_mode_addr;
    w_layer_nxt     = r_layer;
    w_word_nxt      = r_word;
    w_byte_nxt      = r_byte;
    w_word_data_nxt = r_word_data;
    w_done_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Address request wins a tie; the simultaneous data request is dropped.
        if (bus.start_addr_in || bus.start_data_in) begin
          w_mode_addr_nxt = bus.start_addr_in;
          w_layer_nxt     = 3'd0;
          w_word_nxt      = 6'd0;
          w_byte_nxt      = 2'd0;
          w_state_nxt     = ST_CMD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (w_accept) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // RAM data requested in FETCH is valid now.
        w_word_data_nxt = bus.rd_data_in;
        w_byte_nxt      = 2'd0;
        w_state_nxt     = ST_SEND;
      end
      ST_SEND: begin
        if (w_accept) begin
          if (w_last_byte) begin
            w_word_nxt = r_word + 6'd1;
            if (w_last_word) begin
              // Layer stays at its terminal value; the next start clears it.
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              if ((r_word == 6'd63) && !r_mode_addr) begin
                w_layer_nxt = r_layer + 3'd1;
              end else begin
                w_layer_nxt = r_layer;
              end
              w_state_nxt = ST_FETCH;
            end
          end else begin
            w_byte_nxt = r_byte + 2'd1;
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs match it.
  always_comb begin
    w_byte_vld  = 1'b0;
    w_dc        = 1'b0;
    w_byte_data = 8'd0;
    w_rd_en     = 1'b0;
    w_rd_layer  = 3'd0;
    w_rd_word   = 6'd0;
    w_busy      = (w_state_nxt != ST_IDLE);
    w_done      = w_done_nxt;
    case (w_state_nxt)
      ST_CMD: begin
        w_byte_vld  = 1'b1;
        w_byte_data = w_mode_addr_nxt ? CUBE0414_ADDR_WR : CUBE0414_DATA_WR;
      end
      ST_FETCH: begin
        w_rd_en    = 1'b1;
        w_rd_layer = w_layer_nxt;
        w_rd_word  = w_word_nxt;
      end
      ST_SEND: begin
        w_byte_vld  = 1'b1;
        w_dc        = 1'b1;
        w_byte_data = f_sel_byte(w_word_data_nxt, w_byte_nxt, w_mode_addr_nxt);
      end
      default: begin
        w_byte_vld = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_byte_vld  <= 1'b0;
      r_dc        <= 1'b0;
      r_byte_data <= 8'd0;
      r_rd_en     <= 1'b0;
      r_rd_layer  <= 3'd0;
      r_rd_word   <= 6'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_byte_vld  <= w_byte_vld;
      r_dc        <= w_dc;
      r_byte_data <= w_byte_data;
      r_rd_en     <= w_rd_en;
      r_rd_layer  <= w_rd_layer;
      r_rd_word   <= w_rd_word;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign bus.byte_vld_out  = r_byte_vld;
  assign bus.dc_out        = r_dc;
  assign bus.byte_data_out = r_byte_data;
  assign bus.rd_en_out     = r_rd_en;
  assign bus.rd_layer_out  = r_rd_layer;
  assign bus.rd_word_out   = r_rd_word;
  assign bus.busy_out      = r_busy;
  assign bus.done_out      = r_done;

endmodule

// File: doc/cube_stream_tx.md
# cube_stream_tx

Host-side transmitter for the cube LED command/data byte stream. It reads an address table or a full 8-layer frame from a local RAM, serialises it into command bytes (dc=0) and data bytes (dc=1), and presents them over a valid/ready byte handshake to the SPI master that drives the LED controller's layer-control receiver. Byte order and layer order match the receiver exactly, so one data transfer makes the receiver raise its frame-ready pulse.

## Interface
- CUBE0414_ADDR_WR, 8'hcc, command byte opening an address-table upload
- CUBE0414_DATA_WR, 8'hda, command byte opening a frame-data upload
- clk_in  in  1  single clock; all logic on its rising edge
- rst_in  in  1  reset, synchronous, active-high
- start_addr_in  in  1  one-cycle request: send the address table (64 bytes)
- start_data_in  in  1  one-cycle request: send a frame (8 layers × 64 words × 3 bytes)
- rd_en_out  out  1  RAM read strobe
- rd_layer_out  out  3  layer index of the read; 0 in address mode
- rd_word_out  out  6  word index of the read
- rd_data_in  in  24  RAM read data, valid one cycle after rd_en_out; address mode uses [7:0] only
- byte_vld_out  out  1  byte_data_out/dc_out valid
- byte_rdy_in  in  1  downstream accepts the byte when byte_vld_out & byte_rdy_in
- byte_data_out  out  8  byte to send
- dc_out  out  1  0 = command, 1 = data
- busy_out  out  1  high from the cycle after a start is accepted until done_out
- done_out  out  1  one-cycle pulse after the last byte of a transfer is accepted

## Operation
- States: IDLE, CMD, FETCH, LOAD, SEND.
- IDLE: if start_addr_in is high, mode=ADDR. Else if start_data_in is high, mode=DATA. Starting clears layer, word and byte counters and moves to CMD. With both starts high in the same cycle, ADDR wins and the data request is dropped.
- Start requests outside IDLE are ignored; they are not queued.
- CMD: byte_vld_out=1, dc_out=0, byte_data_out = the mode's command. On acceptance go to FETCH.
- FETCH: rd_en_out=1 for exactly one cycle, carrying the current layer and word. Go to LOAD.
- LOAD: capture rd_data_in into a 24-bit word register. Set byte counter = 0. Go to SEND.
- SEND: byte_vld_out=1, dc_out=1.
  - DATA mode: bytes go out as [23:16], then [15:8], then [7:0] for byte counter 0/1/2.
  - ADDR mode: a single byte, [7:0].
- On acceptance of the last byte of a word:
  - Increment the word counter (6-bit, wraps 63→0).
  - On a 63→0 wrap in DATA mode, increment the layer counter.
  - The transfer is complete after word 63 (ADDR mode) or after layer 7, word 63 (DATA mode).
  - If the transfer is complete: pulse done_out and go to IDLE. Otherwise go to FETCH.
- Handshake rule: while byte_vld_out=1 and byte_rdy_in=0, byte_data_out and dc_out stay stable and no counter advances.
- byte_vld_out is low in IDLE, FETCH and LOAD.
- Counters never pass their terminal values. The layer counter is 3-bit and only ever counts 0..7.

## Timing
- Reset: all outputs are 0; the state is IDLE and all counters are 0.
- Reset mid-transfer: outputs drop to 0 on the next edge and the transfer is abandoned. No done_out is produced.
- Start is sampled at edge N. The command byte is valid from cycle N+1.
- With byte_rdy_in held at 1:
  - Each DATA word takes 5 cycles: FETCH, LOAD, then 3 SEND cycles.
  - Each ADDR word takes 3 cycles.
  - A DATA transfer is 1 + 512×5 = 2561 cycles from CMD to the last byte.
  - An ADDR transfer is 1 + 64×3 = 193 cycles.
- done_out is high in the cycle after the last acceptance. busy_out falls in that same cycle.
- A new start may be sampled in the done_out cycle.
- RAM read latency is fixed at 1 cycle.

## Test plan
- Data frame, rdy always 1, RAM word = {layer, word, 8'h5a} packed to 24 bits:
  - Expect byte 0 = 8'hda with dc=0, then 1536 dc=1 bytes in layer 0..7, word 0..63 order, MSB byte first.
  - Expect done_out after exactly 2561 cycles. Fed to the receiver, this produces one frame_rdy pulse.
- Address table, rdy always 1, RAM[w][7:0] = w ^ 8'hff:
  - Expect 8'hcc with dc=0, then bytes ff, fe, …, c0.
  - Expect rd_layer_out = 0 throughout and done_out after 193 cycles.
- Backpressure: rdy toggles with a pseudo-random pattern and is held low for 10 cycles mid-word.
  - Byte, dc and counters hold while stalled. The byte sequence is identical to the first scenario.
  - rd_en_out pulses exactly once per word.
- start_addr_in and start_data_in high together in IDLE: only the ADDR transfer (8'hcc) runs. A start_data_in pulse during busy produces no second transfer.
- rst_in asserted while layer 3, word 17, byte 1 is stalled:
  - Next cycle all outputs are 0 and there is no done_out.
  - A fresh start_data_in restarts cleanly from 8'hda, layer 0, word 0.
- Back-to-back: start_data_in asserted in the done_out cycle of an ADDR transfer → 8'hda is valid on the following cycle.
